// File: rtl/axi_rd_protocol_checker.sv
`default_nettype none
// ==========================================================================
// axi_rd_protocol_checker - passive AXI AR/R channel protocol monitor
// Rev 1.0
// ==========================================================================
module axi_rd_protocol_checker #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int ID_W       = 4,
  parameter int MAX_OUTST  = 8,
  parameter int AR_TIMEOUT = 3,
  parameter int R_TIMEOUT  = 3
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         arvalid,
  input  logic                         arready,
  input  logic [ADDR_W-1:0]            araddr,
  input  logic [ID_W-1:0]              arid,
  input  logic [7:0]                   arlen,
  input  logic [2:0]                   arsize,
  input  logic [1:0]                   arburst,
  input  logic                         rvalid,
  input  logic                         rready,
  input  logic [DATA_W-1:0]            rdata,
  input  logic [ID_W-1:0]              rid,
  input  logic [1:0]                   rresp,
  input  logic                         rlast,
  output logic [7:0]                   err_pulse,
  output logic [7:0]                   err_sticky,
  output logic [15:0]                  err_count,
  output logic [$clog2(MAX_OUTST):0]   outstanding
);

  localparam int c_PTR_W = $clog2(MAX_OUTST);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_ARW_W = $clog2(AR_TIMEOUT + 2);
  localparam int c_RW_W  = $clog2(R_TIMEOUT + 2);
  localparam int c_ARP_W = ADDR_W + ID_W + 8 + 3 + 2;
  localparam int c_RP_W  = DATA_W + ID_W + 2 + 1;

  localparam logic [c_ARW_W-1:0] c_AR_FIRE = c_ARW_W'(AR_TIMEOUT);
  localparam logic [c_ARW_W-1:0] c_AR_SAT  = c_ARW_W'(AR_TIMEOUT + 1);
  localparam logic [c_RW_W-1:0]  c_R_FIRE  = c_RW_W'(R_TIMEOUT);
  localparam logic [c_RW_W-1:0]  c_R_SAT   = c_RW_W'(R_TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(MAX_OUTST);

  logic [7:0]         r_fifo [MAX_OUTST];
  logic [c_PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_CNT_W-1:0] r_outst;
  logic [7:0]         r_beat_cnt;
  logic [c_ARW_W-1:0] r_ar_wait;
  logic [c_RW_W-1:0]  r_r_wait;
  logic               r_ar_stall_q, r_r_stall_q;
  logic [c_ARP_W-1:0] r_ar_pl;
  logic [c_RP_W-1:0]  r_r_pl;
  logic [7:0]         r_err_pulse, r_err_sticky;
  logic [15:0]        r_err_count;

  logic               w_ar_stall, w_ar_hs, w_r_stall, w_r_hs;
  logic               w_empty, w_full, w_beat_last, w_track, w_retire, w_push;
  logic [7:0]         w_head;
  logic [c_ARP_W-1:0] w_ar_pl;
  logic [c_RP_W-1:0]  w_r_pl;
  logic [7:0]         w_err;
  logic [3:0]         w_pop;
  logic [16:0]        w_cnt_sum;

  assign w_ar_stall  = arvalid && !arready;
  assign w_ar_hs     = arvalid && arready;
  assign w_r_stall   = rvalid && !rready;
  assign w_r_hs      = rvalid && rready;
  assign w_ar_pl     = {araddr, arid, arlen, arsize, arburst};
  assign w_r_pl      = {rdata, rid, rresp, rlast};

  assign w_empty     = (r_outst == '0);
  assign w_full      = (r_outst == c_FULL);
  assign w_head      = r_fifo[r_rd_ptr];
  assign w_beat_last = (r_beat_cnt == w_head);
  // Beats arriving with nothing outstanding are reported but never tracked.
  assign w_track     = w_r_hs && !w_empty;
  assign w_retire    = w_track && (rlast || w_beat_last);
  assign w_push      = w_ar_hs && (!w_full || w_retire);

  assign w_err[0] = w_ar_stall && (r_ar_wait == c_AR_FIRE);
  assign w_err[1] = r_ar_stall_q && arvalid && (w_ar_pl != r_ar_pl);
  assign w_err[2] = r_ar_stall_q && !arvalid;
  assign w_err[3] = w_r_stall && (r_r_wait == c_R_FIRE);
  assign w_err[4] = r_r_stall_q && (!rvalid || (w_r_pl != r_r_pl));
  assign w_err[5] = w_r_hs && w_empty;
  assign w_err[6] = w_track && (w_beat_last != rlast);
  assign w_err[7] = w_ar_hs && w_full && !w_retire;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < 8; i++) begin
      w_pop = w_pop + {3'b000, w_err[i]};
    end
  end

  assign w_cnt_sum = {1'b0, r_err_count} + {13'd0, w_pop};

  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= arlen;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_outst      <= '0;
      r_beat_cnt   <= '0;
      r_ar_wait    <= '0;
      r_r_wait     <= '0;
      r_ar_stall_q <= 1'b0;
      r_r_stall_q  <= 1'b0;
      r_ar_pl      <= '0;
      r_r_pl       <= '0;
      r_err_pulse  <= '0;
      r_err_sticky <= '0;
      r_err_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_retire) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_push, w_retire})
        2'b10:   r_outst <= r_outst + c_CNT_W'(1);
        2'b01:   r_outst <= r_outst - c_CNT_W'(1);
        default: r_outst <= r_outst;
      endcase

      if (w_retire) begin
        r_beat_cnt <= '0;
      end else if (w_track) begin
        r_beat_cnt <= r_beat_cnt + 8'd1;
      end

      // Wait counters park one past the limit so each stalled request fires once.
      if (!w_ar_stall) begin
        r_ar_wait <= '0;
      end else if (r_ar_wait != c_AR_SAT) begin
        r_ar_wait <= r_ar_wait + c_ARW_W'(1);
      end
      if (!w_r_stall) begin
        r_r_wait <= '0;
      end else if (r_r_wait != c_R_SAT) begin
        r_r_wait <= r_r_wait + c_RW_W'(1);
      end

      r_ar_stall_q <= w_ar_stall;
      r_r_stall_q  <= w_r_stall;
      r_ar_pl      <= w_ar_pl;
      r_r_pl       <= w_r_pl;

      r_err_pulse  <= w_err;
      r_err_sticky <= r_err_sticky | w_err;
      r_err_count  <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
    end
  end

  assign err_pulse   = r_err_pulse;
  assign err_sticky  = r_err_sticky;
  assign err_count   = r_err_count;
  assign outstanding = r_outst;

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_protocol_checker.sv
`default_nettype none
// ==========================================================================
// tb_axi_rd_protocol_checker - directed scenarios plus random traffic vs model
// Rev 1.0
// ==========================================================================
module tb_axi_rd_protocol_checker;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 64;
  localparam int ID_W       = 4;
  localparam int MAX_OUTST  = 8;
  localparam int AR_TIMEOUT = 3;
  localparam int R_TIMEOUT  = 3;
  localparam int OW         = $clog2(MAX_OUTST) + 1;

  logic              aclk = 1'b0;
  logic              areset;
  logic              arvalid, arready;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid, rready;
  logic [DATA_W-1:0] rdata;
  logic [ID_W-1:0]   rid;
  logic [1:0]        rresp;
  logic              rlast;
  logic [7:0]        err_pulse, err_sticky;
  logic [15:0]       err_count;
  logic [OW-1:0]     outstanding;

  axi_rd_protocol_checker #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W),
    .MAX_OUTST(MAX_OUTST), .AR_TIMEOUT(AR_TIMEOUT), .R_TIMEOUT(R_TIMEOUT)
  ) u_dut (
    .aclk(aclk), .areset(areset),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid),
    .rresp(rresp), .rlast(rlast),
    .err_pulse(err_pulse), .err_sticky(err_sticky),
    .err_count(err_count), .outstanding(outstanding)
  );

  always #5 aclk = ~aclk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: outstanding bursts as a queue of arlen values.
  int        m_q[$];
  int        m_beats, m_arw, m_rw, m_cnt;
  bit        m_ar_st, m_r_st;
  logic [ADDR_W+ID_W+12:0] m_ar_pl;
  logic [DATA_W+ID_W+2:0]  m_r_pl;
  logic [7:0] m_pulse, m_sticky;

  task automatic model_step();
    logic [7:0] e;
    bit retired, last_beat, ar_st, r_st;
    logic [ADDR_W+ID_W+12:0] ar_pl;
    logic [DATA_W+ID_W+2:0]  r_pl;
    if (areset) begin
      m_q.delete();
      m_beats = 0; m_arw = 0; m_rw = 0; m_cnt = 0;
      m_ar_st = 0; m_r_st = 0;
      m_pulse = '0; m_sticky = '0;
      return;
    end
    e = '0;
    ar_st = arvalid && !arready;
    r_st  = rvalid && !rready;
    ar_pl = {araddr, arid, arlen, arsize, arburst};
    r_pl  = {rdata, rid, rresp, rlast};
    if (ar_st) begin
      m_arw++;
      if (m_arw == AR_TIMEOUT + 1) e[0] = 1'b1;
    end else m_arw = 0;
    if (r_st) begin
      m_rw++;
      if (m_rw == R_TIMEOUT + 1) e[3] = 1'b1;
    end else m_rw = 0;
    e[1] = m_ar_st && arvalid && (ar_pl != m_ar_pl);
    e[2] = m_ar_st && !arvalid;
    e[4] = m_r_st && (!rvalid || (r_pl != m_r_pl));
    retired = 0;
    if (rvalid && rready) begin
      if (m_q.size() == 0) e[5] = 1'b1;
      else begin
        last_beat = (m_beats == m_q[0]);
        if (last_beat != rlast) e[6] = 1'b1;
        if (last_beat || rlast) begin retired = 1; m_beats = 0; end
        else m_beats++;
      end
    end
    if (arvalid && arready) begin
      if (m_q.size() >= MAX_OUTST && !retired) e[7] = 1'b1;
      else m_q.push_back(int'(arlen));
    end
    if (retired) void'(m_q.pop_front());
    m_ar_st = ar_st; m_r_st = r_st; m_ar_pl = ar_pl; m_r_pl = r_pl;
    m_pulse  = e;
    m_sticky = m_sticky | e;
    m_cnt    = (m_cnt + $countones(e) > 65535) ? 65535 : m_cnt + $countones(e);
  endtask

  task automatic tick();
    model_step();
    @(posedge aclk);
    #1;
    check_eq("pulse",  32'(err_pulse),   32'(m_pulse));
    check_eq("sticky", 32'(err_sticky),  32'(m_sticky));
    check_eq("count",  32'(err_count),   32'(m_cnt));
    check_eq("outst",  32'(outstanding), 32'(m_q.size()));
  endtask

  task automatic idle();
    arvalid = 0; arready = 0; rvalid = 0; rready = 0; rlast = 0;
  endtask

  task automatic do_reset();
    idle();
    areset = 1; tick(); tick(); areset = 0;
  endtask

  task automatic ar_req(input logic [7:0] len, input int delay);
    arvalid = 1; araddr = $urandom; arid = 4'($urandom); arlen = len;
    arsize = 3'd3; arburst = 2'd1; arready = 0;
    repeat (delay) tick();
    arready = 1; tick();
    arvalid = 0; arready = 0;
  endtask

  task automatic r_beat(input logic last);
    rvalid = 1; rready = 1; rlast = last; rdata = {$urandom, $urandom};
    tick();
    rvalid = 0; rready = 0; rlast = 0;
  endtask

  initial begin
    bit ar_hs_prev, r_hs_prev;
    int ar_pct, r_pct;
    areset = 1; idle();
    araddr = '0; arid = '0; arlen = '0; arsize = '0; arburst = '0;
    rdata = '0; rid = '0; rresp = '0;
    do_reset();
    check_eq("rst_pulse", 32'(err_pulse), 32'h0);
    check_eq("rst_outst", 32'(outstanding), 32'h0);

    // Clean 4-beat burst.
    ar_req(8'd3, 1);
    check_eq("t1_outst1", 32'(outstanding), 32'd1);
    for (int i = 0; i < 4; i++) r_beat(i == 3);
    check_eq("t1_outst0", 32'(outstanding), 32'd0);
    check_eq("t1_sticky", 32'(err_sticky), 32'd0);

    // AR timeout fires once.
    do_reset();
    arvalid = 1; arready = 0; arlen = 8'd0;
    repeat (5) tick();
    check_eq("t2_count", 32'(err_count), 32'd1);
    check_eq("t2_sticky", 32'(err_sticky), 32'h01);
    arready = 1; tick(); idle();
    r_beat(1'b1);

    // Payload instability on AR and R.
    do_reset();
    arvalid = 1; arready = 0; araddr = 32'h100; arlen = 8'd0; tick();
    araddr = 32'h104; tick();
    check_eq("t3_ar_unstable", 32'(err_pulse[1]), 32'd1);
    arready = 1; tick(); arvalid = 0; arready = 0;
    rvalid = 1; rready = 0; rlast = 1; rdata = 64'hA; tick();
    rdata = 64'hB; tick();
    check_eq("t3_r_unstable", 32'(err_pulse[4]), 32'd1);
    rready = 1; tick(); idle();
    check_eq("t3_outst", 32'(outstanding), 32'd0);

    // Early rlast then orphan beat.
    do_reset();
    ar_req(8'd1, 0);
    r_beat(1'b1);
    check_eq("t4_rlast_err", 32'(err_pulse), 32'h40);
    check_eq("t4_outst", 32'(outstanding), 32'd0);
    r_beat(1'b1);
    check_eq("t4_orphan", 32'(err_pulse), 32'h20);

    // FIFO overflow and retire-covered push.
    do_reset();
    arvalid = 1; arready = 1; arlen = 8'd0;
    repeat (9) tick();
    check_eq("t5_ovf", 32'(err_pulse), 32'h80);
    check_eq("t5_outst", 32'(outstanding), 32'd8);
    rvalid = 1; rready = 1; rlast = 1; tick();
    check_eq("t5_no_ovf", 32'(err_pulse), 32'h00);
    check_eq("t5_outst_hold", 32'(outstanding), 32'd8);
    idle();
    repeat (8) r_beat(1'b1);
    check_eq("t5_drained", 32'(outstanding), 32'd0);

    // Reset mid-burst, then a clean burst.
    do_reset();
    ar_req(8'd3, 0);
    r_beat(1'b0); r_beat(1'b0);
    areset = 1; tick(); areset = 0;
    check_eq("t6_rst_outst", 32'(outstanding), 32'd0);
    check_eq("t6_rst_count", 32'(err_count), 32'd0);
    ar_req(8'd3, 0);
    for (int i = 0; i < 4; i++) r_beat(i == 3);
    check_eq("t6_sticky", 32'(err_sticky), 32'd0);
    check_eq("t6_outst", 32'(outstanding), 32'd0);

    // Random traffic.
    ar_hs_prev = 0; r_hs_prev = 0; ar_pct = 60; r_pct = 60;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 64 == 0) begin
        case ($urandom_range(0, 2))
          0: ar_pct = 15;
          1: ar_pct = 60;
          default: ar_pct = 95;
        endcase
        case ($urandom_range(0, 2))
          0: r_pct = 15;
          1: r_pct = 60;
          default: r_pct = 95;
        endcase
      end
      areset = ($urandom_range(0, 599) == 0);
      if (!arvalid || ar_hs_prev) begin
        arvalid = ($urandom_range(0, 1) == 1);
        araddr = $urandom; arid = 4'($urandom); arlen = 8'($urandom_range(0, 3));
        arsize = 3'($urandom); arburst = 2'($urandom);
      end else begin
        case ($urandom_range(0, 39))
          0: arvalid = 0;
          1: araddr = araddr + 32'd4;
          2: arlen = arlen + 8'd1;
          default: ;
        endcase
      end
      arready = ($urandom_range(0, 99) < ar_pct);
      if (!rvalid || r_hs_prev) begin
        rvalid = (m_q.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0);
        rdata = {$urandom, $urandom}; rid = 4'($urandom); rresp = 2'($urandom);
        rlast = (m_q.size() > 0) && (m_beats == m_q[0]);
        if ($urandom_range(0, 15) == 0) rlast = !rlast;
      end else begin
        case ($urandom_range(0, 39))
          0: rvalid = 0;
          1: rdata = rdata ^ 64'h1;
          2: rlast = !rlast;
          default: ;
        endcase
      end
      rready = ($urandom_range(0, 99) < r_pct);
      ar_hs_prev = arvalid && arready;
      r_hs_prev  = rvalid && rready;
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
